// File: rtl/alu_exec.sv
// Execute-stage ALU with valid/ready handshakes, a registered result and an iterative 1-bit/cycle shifter.
// Define ALU_EXEC_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_op,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 4;
  localparam int unsigned SHW = 5;

  localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPW-1:0] OP_SUB  = 4'b1000;
  localparam logic [OPW-1:0] OP_SLL  = 4'b0001;
  localparam logic [OPW-1:0] OP_SRL  = 4'b0101;
  localparam logic [OPW-1:0] OP_SRA  = 4'b1101;
  localparam logic [OPW-1:0] OP_SLT  = 4'b0010;
  localparam logic [OPW-1:0] OP_SLTU = 4'b0011;
  localparam logic [OPW-1:0] OP_XOR  = 4'b0100;
  localparam logic [OPW-1:0] OP_OR   = 4'b0110;
  localparam logic [OPW-1:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifndef ALU_EXEC_BARREL_EN
    S_SHIFT = 2'd2,
`endif
    S_DONE  = 2'd1
  } state_t;

  // Single-cycle result; in the iterative build shifts only reach here with shamt=0.
  function automatic logic [DW-1:0] f_alu(input logic [OPW-1:0] op,
                                          input logic [DW-1:0]  a,
                                          input logic [DW-1:0]  b);
    logic [DW-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
`ifdef ALU_EXEC_BARREL_EN
      OP_SLL:  r = a << b[SHW-1:0];
      OP_SRL:  r = a >> b[SHW-1:0];
      OP_SRA:  r = DW'($signed(a) >>> b[SHW-1:0]);
`else
      OP_SLL, OP_SRL, OP_SRA: r = a;
`endif
      OP_SLT:  r = {(DW-1)'(0), ($signed(a) < $signed(b))};
      OP_SLTU: r = {(DW-1)'(0), (a < b)};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_result, w_result_nxt;
  logic            r_zero, w_zero_nxt;
  logic            r_in_ready, w_in_ready_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic [DW-1:0]   w_alu;

`ifndef ALU_EXEC_BARREL_EN
  logic [DW-1:0]   r_work, w_work_nxt, w_work_shift;
  logic [SHW-1:0]  r_cnt, w_cnt_nxt;
  logic            r_shl, w_shl_nxt;
  logic            r_arith, w_arith_nxt;
  logic            w_is_shift;

  assign w_is_shift   = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  assign w_work_shift = r_shl ? {r_work[DW-2:0], 1'b0}
                              : {r_arith & r_work[DW-1], r_work[DW-1:1]};
`endif

  assign w_alu     = f_alu(alu_op, rs1_data, rs2_data);
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifndef ALU_EXEC_BARREL_EN
      r_work      <= '0;
      r_cnt       <= '0;
      r_shl       <= 1'b0;
      r_arith     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_result    <= w_result_nxt;
      r_zero      <= w_zero_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
`ifndef ALU_EXEC_BARREL_EN
      r_work      <= w_work_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shl       <= w_shl_nxt;
      r_arith     <= w_arith_nxt;
`endif
    end
  end

  // Next state, datapath updates and registered handshake flags.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
`ifndef ALU_EXEC_BARREL_EN
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_shl_nxt    = r_shl;
    w_arith_nxt  = r_arith;
`endif
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
`ifndef ALU_EXEC_BARREL_EN
          if (w_is_shift && (rs2_data[SHW-1:0] != '0)) begin
            w_work_nxt  = rs1_data;
            w_cnt_nxt   = rs2_data[SHW-1:0];
            w_shl_nxt   = (alu_op == OP_SLL);
            w_arith_nxt = (alu_op == OP_SRA);
            w_state_nxt = S_SHIFT;
          end else begin
`else
          begin
`endif
            w_result_nxt = w_alu;
            w_zero_nxt   = (w_alu == '0);
            w_state_nxt  = S_DONE;
          end
        end
      end
`ifndef ALU_EXEC_BARREL_EN
      // The last shift step writes the result directly so latency is shamt+1.
      S_SHIFT: begin
        w_work_nxt = w_work_shift;
        w_cnt_nxt  = r_cnt - SHW'(1);
        if (r_cnt == SHW'(1)) begin
          w_result_nxt = w_work_shift;
          w_zero_nxt   = (w_work_shift == '0);
          w_state_nxt  = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vector table, backpressure and reset corner cases, random scoreboard stream.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]  alu_op;
  logic [31:0] rs1_data, rs2_data, result;

  alu_exec dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  vec_t        vecs[16];
  logic [3:0]  ops[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit is_shift(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1101);
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_EXEC_BARREL_EN
    return 1;
`else
    if (is_shift(op) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Reference model: shifts are stepped bit by bit, signed compare via sign bits.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b[4:0]);
    r  = 32'd0;
    case (op)
      4'b0000: r = a + b;
      4'b1000: r = a + ~b + 32'd1;
      4'b0001: begin r = a; for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0}; end
      4'b0101: begin r = a; for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]}; end
      4'b1101: begin r = a; for (int i = 0; i < sh; i++) r = {r[31], r[31:1]}; end
      4'b0010: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'b0011: r = {31'd0, (a < b)};
      4'b0100: r = a ^ b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res);
    int lat;
    alu_op = op; rs1_data = a; rs2_data = b; in_valid = 1'b1; out_ready = 1'b1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    alu_op = 4'($urandom); rs1_data = $urandom; rs2_data = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(lat_of(op, b)));
    chk({name, "_result"}, result, exp_res);
    chk({name, "_zero"}, 32'(zero), 32'(exp_res == 32'd0));
    tick();
    chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          lat;
    logic        stale;
    int          n_sent, n_recv;
    logic        extra;

    vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[1]  = '{4'b1000, 32'h00000005, 32'h00000005, 32'h00000000};
    vecs[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    vecs[3]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[4]  = '{4'b1111, 32'h12345678, 32'h00000009, 32'h00000000};
    vecs[5]  = '{4'b1101, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF};
    vecs[6]  = '{4'b0101, 32'h80000000, 32'h0000001F, 32'h00000001};
    vecs[7]  = '{4'b0001, 32'h00000001, 32'h00000025, 32'h00000020};
    vecs[8]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    vecs[9]  = '{4'b0110, 32'h0F000000, 32'h000000F0, 32'h0F0000F0};
    vecs[10] = '{4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[11] = '{4'b0001, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF};
    vecs[12] = '{4'b1101, 32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF};
    vecs[13] = '{4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[14] = '{4'b0010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[15] = '{4'b1001, 32'h00000003, 32'h00000004, 32'h00000000};
    ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101, 4'b0010,
            4'b0011, 4'b0100, 4'b0110, 4'b0111, 4'b1111};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'd0; rs1_data = 32'd0; rs2_data = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);

    for (int i = 0; i < 16; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);

    // Backpressure: hold DONE for 10 cycles with an ignored request in the middle.
    alu_op = 4'b0000; rs1_data = 32'd3; rs2_data = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_result_c%0d", i), result, 32'd7);
      chk($sformatf("bp_in_ready_c%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_out_valid_c%0d", i), 32'(out_valid), 32'd1);
      if (i == 3) begin
        alu_op = 4'b1000; rs1_data = 32'd100; rs2_data = 32'd1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    chk("bp_ignored_request", 32'(stale), 32'd0);

    // Reset in the third cycle of a shamt=20 shift.
    alu_op = 4'b0001; rs1_data = 32'd1; rs2_data = 32'd20; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_zero", 32'(zero), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) stale = 1'b1;
    end
    chk("rst_mid_no_stale", 32'(stale), 32'd0);

    // Random stream against the scoreboard.
    n_sent = 0; n_recv = 0; extra = 1'b0;
    fork
      begin
        int guard = 0;
        while (n_sent < 100 && guard < 20000) begin
          if (!in_valid && ($urandom_range(3) != 0)) begin
            alu_op = ops[$urandom_range(10)];
            rs1_data = $urandom;
            rs2_data = ($urandom_range(1) == 1) ? 32'($urandom_range(31)) : $urandom;
            in_valid = 1'b1;
          end
          if (in_valid && in_ready) begin
            sb_q.push_back(ref_alu(alu_op, rs1_data, rs2_data));
            n_sent++;
            tick();
            in_valid = 1'b0;
          end else begin
            tick();
          end
          guard++;
        end
        in_valid = 1'b0;
      end
      begin
        int guard = 0;
        logic [31:0] exp;
        while (n_recv < 100 && guard < 20000) begin
          out_ready = 1'($urandom_range(1));
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
              extra = 1'b1;
            end else begin
              exp = sb_q.pop_front();
              chk($sformatf("stream%0d_result", n_recv), result, exp);
              chk($sformatf("stream%0d_zero", n_recv), 32'(zero), 32'(exp == 32'd0));
            end
            n_recv++;
          end
          tick();
          guard++;
        end
      end
    join
    chk("stream_recv_count", 32'(n_recv), 32'd100);
    chk("stream_sent_count", 32'(n_sent), 32'd100);
    chk("stream_no_extra", 32'(extra), 32'd0);
    chk("stream_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU that consumes the 4-bit `ALUop` produced by the control unit together with two 32-bit operands and returns a registered result. Operands are accepted through a valid/ready handshake. Results are delivered the same way. Shifts run iteratively, one bit per cycle, unless the barrel-shifter build option is enabled. The block sits between decode/register-read and write-back and backpressures decode while it is busy.

## Interface
- No parameters; the datapath is fixed at 32 bits and `ALUop` at 4 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operation request valid.
- `in_ready` output 1: block can accept an operation; high only in IDLE.
- `alu_op` input 4: ALUop encoding from the control unit.
- `rs1_data` input 32: operand A.
- `rs2_data` input 32: operand B; bits [4:0] are the shift amount for shifts.
- `out_valid` output 1: `result` is valid.
- `out_ready` input 1: write-back consumes `result`.
- `result` output 32: registered ALU result.
- `zero` output 1: registered flag, equal to (`result` == 0).

## Operation
- Encoding:
  - 0000 add; 1000 sub.
  - 0001 sll; 0101 srl; 1101 sra.
  - 0010 slt (signed, result 1 or 0); 0011 sltu (unsigned, result 1 or 0).
  - 0100 xor; 0110 or; 0111 and.
  - Any other code produces result 0 with normal 1-cycle completion.
- Arithmetic wraps modulo 2^32; no overflow or carry output.
- States: IDLE, SHIFT, DONE.
  - **IDLE**: `in_ready`=1. When `in_valid`=1 the block captures `alu_op` and the operands.
    - Non-shift op, or shift with shamt=0: the result is written and the state goes to DONE.
    - Shift with shamt>0: A is loaded into the working register, the counter is loaded with shamt, and the state goes to SHIFT.
  - **SHIFT**: each cycle the working register shifts by one bit and the counter decrements.
    - sll fills with 0; srl fills with 0; sra fills with bit 31.
    - When the counter reaches 0, `result` is taken from the working register and the state goes to DONE.
  - **DONE**: `out_valid`=1, and `result` and `zero` are held stable.
    - When `out_ready`=1, the state returns to IDLE.
    - With `out_ready`=0 the block holds indefinitely.
- `in_valid` and the operand inputs are ignored outside IDLE. Operands are captured, so upstream may change them after the handshake.
- Reset:
  - state goes to IDLE; `result`=0, `zero`=0, `out_valid`=0, counter=0.
  - Reset takes priority over every other event, including mid-SHIFT and in DONE; any in-flight operation is discarded.
  - `in_ready`=1 in the first cycle after `rst` deasserts.

## Timing
- Acceptance occurs on the edge where `in_valid`=1 and `in_ready`=1.
- Non-shift or shamt=0: `out_valid` rises 1 cycle after the accept edge.
- Iterative shift: `out_valid` rises shamt+1 cycles after the accept edge. Maximum is 32 cycles for shamt=31.
- Delivery occurs on the edge where `out_valid`=1 and `out_ready`=1. `in_ready` rises in the following cycle.
- The block is not pipelined: peak throughput is one operation per 2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `ALU_EXEC_BARREL_EN` defined:
  - All shifts complete in 1 cycle through a combinational barrel shifter.
  - The SHIFT state and the counter are removed.
  - Every op has a latency of 1 cycle.
- `ALU_EXEC_BARREL_EN` undefined: iterative shifter as described above.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- add A=0x7FFFFFFF, B=1 → result 0x80000000, zero=0, `out_valid` 1 cycle after accept. Then sub A=5, B=5 → result 0, zero=1.
- slt A=0xFFFFFFFF, B=1 → 1. sltu with the same operands → 0. Undefined op 1111 → result 0, zero=1.
- sra A=0x80000000, B=31 → 0xFFFFFFFF after 32 cycles (1 cycle with `ALU_EXEC_BARREL_EN`). srl with the same operands → 0x00000001. sll A=1, B=0x25 → uses shamt 5, result 0x20.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `result` stable and `in_ready`=0 throughout. A new `in_valid` pulse during that window is ignored. After release, `in_ready`=1 in the next cycle.
- Reset mid-SHIFT: assert `rst` at cycle 3 of a shamt=20 shift → next cycle `out_valid`=0, `result`=0, `in_ready`=1. No stale result appears afterwards.
- Back-to-back stream of 100 random ops with random `out_ready` → results match the reference model in order, with no drops or duplicates.
